// File: rtl/fifo_pkg.sv
// Shared constants and types for the FWFT FIFO reader and its output queue.
package fifo_pkg;

   localparam int FIFO_DATA_W = 128;
   localparam int FWFT_DEPTH  = 3;
   localparam int LEVEL_W     = 2;

   typedef logic [LEVEL_W-1:0] level_t;

endpackage

// File: rtl/fwft_out_buf.sv
// Three-entry ordered register queue; head entry is always the oldest word.
module fwft_out_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  clear,
   output level_t                level,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] mem_q [FWFT_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FWFT_DEPTH];
   level_t                level_q;
   level_t                level_d;
   level_t                wr_idx;

   always_comb begin
      mem_d   = mem_q;
      level_d = level_q;
      wr_idx  = level_q;
      // A pop shifts the queue first so a same-cycle push lands behind the survivors.
      if (pop && (level_q != '0)) begin
         for (int i = 0; i < FWFT_DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         level_d = level_q - 2'd1;
         wr_idx  = level_q - 2'd1;
      end
      if (push && (wr_idx < 2'(FWFT_DEPTH))) begin
         mem_d[wr_idx] = push_data;
         level_d       = level_d + 2'd1;
      end
      if (clear) begin
         level_d = '0;
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         level_q <= '0;
         for (int i = 0; i < FWFT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         mem_q   <= mem_d;
      end
   end

   assign level = level_q;
   assign head  = mem_q[0];

   overflow_a: assert property (@(posedge clk) disable iff (srst)
      !(push && (level_q == 2'(FWFT_DEPTH))));

endmodule

// File: rtl/fifo_fwft_reader.sv
// Turns a 1-cycle-latency synchronous FIFO read port into a first-word-fall-through valid/ready stream.
module fifo_fwft_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W,
   parameter int BUF_DEPTH  = FWFT_DEPTH
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  flush,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [1:0]            buf_level
);

   logic   in_flight_q;
   logic   in_flight_d;
   logic   rd_room;
   logic   push;
   logic   pop;
   level_t level;

   // Room is reserved for the word already in flight; m_ready is deliberately left out.
   assign rd_room     = ({1'b0, level} + {2'b00, in_flight_q}) < 3'(BUF_DEPTH);
   assign fifo_rd_en  = !fifo_empty && !flush && !srst && rd_room;
   assign in_flight_d = fifo_rd_en;

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         in_flight_q <= 1'b0;
      end else begin
         in_flight_q <= in_flight_d;
      end
   end

   // A word landing during flush belongs to a read issued before the flush and is dropped.
   assign push    = in_flight_q && !flush;
   assign m_valid = (level != '0);
   assign pop     = m_valid && m_ready;

   fwft_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .srst      (srst),
      .push      (push),
      .push_data (fifo_dout),
      .pop       (pop),
      .clear     (flush),
      .level     (level),
      .head      (m_data)
   );

   assign buf_level = level;

   no_underflow_a: assert property (@(posedge clk) disable iff (srst)
      !(fifo_rd_en && fifo_empty));

endmodule
